mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle data-memory access engine that executes the byte/half/word load and store requests issued by the decode stage's 4-bit `read_write` access code. It sits between the datapath (address from ALU, store data from rs2) and a byte-wide synchronous data SRAM. It serialises each access into byte transfers, assembles little-endian read data with sign/zero extension, and flags misaligned halfword/word accesses.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM byte-address width (1 KiB); `addr` bits above `ADDR_W-1` ignored.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only while idle.
- `read_write`  in  4  access code: 1000 lb, 1001 lh, 1010 lw, 1100 lbu, 1101 lhu, 1011 sb, 1110 sh, 1111 sw; bit3=0 means no access.
- `addr`  in  32  byte address of access.
- `wdata`  in  32  store data (low bytes used for sb/sh).
- `rdata`  out  32  extended load result.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  misaligned flag, valid with `done`.
- `mem_addr`  out  ADDR_W  SRAM byte address.
- `mem_wdata`  out  8  SRAM write byte.
- `mem_we`  out  1  SRAM write enable.
- `mem_re`  out  1  SRAM read enable.
- `mem_rdata`  in  8  SRAM read byte, valid the cycle after `mem_re`.

## Operation
- States: IDLE, WRITE, READ, FINISH. All outputs registered.
- Accept: in IDLE with `start`=1 and `read_write[3]`=1, latch code, `addr[ADDR_W-1:0]`, `wdata`; later input changes ignored. `start` with bit3=0 ignored.
- Size N: bytes=1 (codes 1000,1100,1011), halves=2 (1001,1101,1110), words=4 (1010,1111).
- Misalignment: N=2 with addr[0]=1, or N=4 with addr[1:0]≠0 -> go to FINISH directly; no SRAM strobe; `err`=1 with `done`; `rdata` unchanged.
- WRITE: for k=0..N-1, one byte per cycle: `mem_we`=1, `mem_addr`=base+k, `mem_wdata`=wdata[8k+7:8k] (little-endian). Then FINISH.
- READ: for k=0..N-1, `mem_re`=1, `mem_addr`=base+k, one per cycle; byte k captured from `mem_rdata` one cycle after its issue into lane k. After last capture, `rdata` = assembled value, sign-extended from bit 8N-1 for lb/lh, zero-extended for lbu/lhu, unmodified for lw. Then FINISH.
- FINISH: `done`=1, `busy`=0, returns to IDLE; `start` in the FINISH cycle is accepted (back-to-back).
- `busy`=1 from the cycle after accept through the last transfer/capture cycle.
- `mem_we`/`mem_re`=0 outside transfer cycles; `mem_addr`/`mem_wdata` hold last value.
- `rdata` holds until the next successful load completes; stores never alter it.
- `err`=0 on every non-misaligned completion.

## Timing
- Cycle 0 = cycle in which `start` is accepted.
- Store: writes in cycles 1..N; `done` in cycle N+1 (sb 2, sh 3, sw 5).
- Load: reads issued cycles 1..N, captures cycles 2..N+1; `done` and final `rdata` in cycle N+2 (lb 3, lh 4, lw 6).
- Misaligned: `done`=`err`=1 in cycle 1.
- `start` in cycles 1..completion-1 ignored; no queuing.
- Reset (any time, asynchronous): `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, state IDLE; in-flight access aborted, no `done`.
- Address arithmetic base+k is modulo 2^ADDR_W (never wraps for aligned accesses).

## Test plan
- sw 0xDEADBEEF at 0x010 -> `mem_we` cycles 1–4 with addr 0x010..0x013, bytes EF,BE,AD,DE; `done` cycle 5, `err`=0, `rdata` unchanged.
- lb at 0x011 (SRAM holds 0xBE) -> `rdata`=0xFFFFFFBE, `done` cycle 3; lbu same address -> 0x000000BE.
- lh at 0x012 (bytes AD,DE) -> 0xFFFFDEAD, `done` cycle 4; lhu -> 0x0000DEAD; lw at 0x010 -> 0xDEADBEEF, `done` cycle 6.
- sh at 0x013 and lw at 0x012 -> no `mem_we`/`mem_re`; `done`=`err`=1 in cycle 1; `rdata` unchanged.
- `start` pulsed in cycles 1–4 during lw, and with `read_write`=0000 while idle -> ignored; new `start` in FINISH cycle -> accepted, next access begins cycle 1 after.
- `rst` asserted in cycle 3 of lw -> all outputs zero immediately, no `done`; after release, sb 0x5A at 0x000 completes normally in 2 cycles.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and byte-wide SRAM signals of the memory access unit.
interface mem_access_unit_if #(parameter int ADDR_W = 10);
    logic              start;
    logic [3:0]        read_write;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport slave (
        input  start, read_write, addr, wdata, mem_rdata,
        output rdata, busy, done, err, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output start, read_write, addr, wdata, mem_rdata,
        input  rdata, busy, done, err, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/mem_access_unit.sv
// Serialises byte/half/word loads and stores into byte transfers on a
// synchronous byte SRAM; assembles little-endian load data with extension.
module mem_byte_lane #(parameter int VEC_W = 8) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [VEC_W-1:0] din,
    output logic [VEC_W-1:0] nxt
);
    logic [VEC_W-1:0] q;

    // nxt exposes the byte being captured this cycle so the final lane can be
    // folded into rdata on the same edge it is captured.
    assign nxt = cap ? din : q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= nxt;
    end
endmodule

module mem_access_unit #(parameter int ADDR_W = 10) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int STAGES    = 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

    typedef struct packed {
        logic       store;
        logic       sext;
        logic [1:0] last;
    } acc_t;

    function automatic acc_t decode(input logic [2:0] c);
        acc_t a;
        case (c)
            3'b000:  a = '{store: 1'b0, sext: 1'b1, last: 2'd0};
            3'b001:  a = '{store: 1'b0, sext: 1'b1, last: 2'd1};
            3'b010:  a = '{store: 1'b0, sext: 1'b0, last: 2'd3};
            3'b100:  a = '{store: 1'b0, sext: 1'b0, last: 2'd0};
            3'b101:  a = '{store: 1'b0, sext: 1'b0, last: 2'd1};
            3'b011:  a = '{store: 1'b1, sext: 1'b0, last: 2'd0};
            3'b110:  a = '{store: 1'b1, sext: 1'b0, last: 2'd1};
            default: a = '{store: 1'b1, sext: 1'b0, last: 2'd3};
        endcase
        return a;
    endfunction

    state_t                              state_q, state_d;
    acc_t                                acc_q, acc_d, req_acc;
    logic [ADDR_W-1:0]                   base_q, base_d;
    logic [NUM_LANES-1:0][VEC_W-1:0]     wdata_q, wdata_d;
    logic [1:0]                          cnt_q, cnt_d, cap_lane_q;
    logic [STAGES:0]                     vld_pipe;
    logic                                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [31:0]                         rdata_q, rdata_d, ext;
    logic [ADDR_W-1:0]                   maddr_q, maddr_d;
    logic [VEC_W-1:0]                    mwdata_q, mwdata_d;
    logic                                we_q, we_d, re_d, misalign;
    logic [NUM_LANES-1:0]                cap_en;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_nxt;

    // vld_pipe[0] is the read issue (drives mem_re); vld_pipe[STAGES] marks
    // the cycle its byte is returned by the SRAM.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign cap_en[i] = vld_pipe[STAGES] && (cap_lane_q == 2'(i));
        mem_byte_lane #(.VEC_W(VEC_W)) u_lane (
            .clk (clk),
            .rst (rst),
            .cap (cap_en[i]),
            .din (bus.mem_rdata),
            .nxt (lane_nxt[i])
        );
    end

    always_comb begin
        ext = lane_nxt;
        case (acc_q.last)
            2'd0:    ext = {{24{acc_q.sext & lane_nxt[0][7]}}, lane_nxt[0]};
            2'd1:    ext = {{16{acc_q.sext & lane_nxt[1][7]}}, lane_nxt[1], lane_nxt[0]};
            default: ext = lane_nxt;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        req_acc  = decode(bus.read_write[2:0]);
        misalign = (req_acc.last == 2'd1 && bus.addr[0]) ||
                   (req_acc.last == 2'd3 && bus.addr[1:0] != 2'b00);
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (bus.start && bus.read_write[3]) begin
                    acc_d   = req_acc;
                    base_d  = bus.addr[ADDR_W-1:0];
                    wdata_d = bus.wdata;
                    cnt_d   = '0;
                    if (misalign) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        maddr_d = bus.addr[ADDR_W-1:0];
                        if (req_acc.store) begin
                            state_d  = WRITE;
                            we_d     = 1'b1;
                            mwdata_d = bus.wdata[7:0];
                        end else begin
                            state_d = READ;
                            re_d    = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt_q == acc_q.last) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 2'd1;
                    we_d     = 1'b1;
                    maddr_d  = base_q + ADDR_W'(cnt_d);
                    mwdata_d = wdata_q[cnt_d];
                end
            end
            READ: begin
                // A READ cycle with no issue is the trailing capture of the last byte.
                if (!vld_pipe[0]) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = ext;
                end else if (cnt_q != acc_q.last) begin
                    cnt_d   = cnt_q + 2'd1;
                    re_d    = 1'b1;
                    maddr_d = base_q + ADDR_W'(cnt_d);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            cap_lane_q <= '0;
            vld_pipe   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            cap_lane_q <= cnt_q;
            vld_pipe   <= {vld_pipe[STAGES-1:0], re_d};
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            we_q       <= we_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_re    = vld_pipe[0];
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: predicted completions, SRAM writes and
// read issues are queued at issue time and compared as the DUT produces them.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if #(.ADDR_W(10)) bus ();
    mem_access_unit #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int cyc; logic [31:0] rdata; logic err; } done_t;
    typedef struct { int cyc; logic [9:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic [9:0] addr; } rd_t;

    done_t dq[$];
    wr_t   wq[$];
    rd_t   rq[$];
    done_t me;
    wr_t   mw;
    rd_t   mr;

    logic [7:0]  sram    [1024];
    logic [7:0]  ref_mem [1024];
    logic [31:0] cur_rdata = '0;
    int          bfrom = 1, bto = 0, last_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr];
    end

    always @(negedge clk) begin
        if (bus.done) begin
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                me = dq.pop_front();
                chk("done_cycle", cyc, me.cyc);
                chk("rdata", bus.rdata, me.rdata);
                chk("err", bus.err, me.err);
            end
        end
        if (bus.mem_we) begin
            if (wq.size() == 0) chk("we_unexpected", 1, 0);
            else begin
                mw = wq.pop_front();
                chk("we_cycle", cyc, mw.cyc);
                chk("we_addr", bus.mem_addr, mw.addr);
                chk("we_data", bus.mem_wdata, mw.data);
            end
        end
        if (bus.mem_re) begin
            if (rq.size() == 0) chk("re_unexpected", 1, 0);
            else begin
                mr = rq.pop_front();
                chk("re_cycle", cyc, mr.cyc);
                chk("re_addr", bus.mem_addr, mr.addr);
            end
        end
        chk("busy", bus.busy, (cyc >= bfrom && cyc <= bto) ? 1 : 0);
    end

    // Called at posedge+1 of a cycle in which the DUT is idle or finishing.
    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] wd);
        int n; logic st, sx, mis; logic [31:0] v; logic [9:0] ma;
        n = 4; st = 1'b0; sx = 1'b0;
        case (code)
            4'b1000: begin n = 1; sx = 1'b1; end
            4'b1001: begin n = 2; sx = 1'b1; end
            4'b1010: n = 4;
            4'b1100: n = 1;
            4'b1101: n = 2;
            4'b1011: begin n = 1; st = 1'b1; end
            4'b1110: begin n = 2; st = 1'b1; end
            default: begin n = 4; st = 1'b1; end
        endcase
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        bus.start = 1'b1; bus.read_write = code; bus.addr = a; bus.wdata = wd;
        if (mis) begin
            dq.push_back('{cyc + 1, cur_rdata, 1'b1});
            bfrom = cyc + 1; bto = cyc;
            last_done = cyc + 1;
        end else if (st) begin
            for (int k = 0; k < n; k++) begin
                ma = a[9:0] + 10'(k);
                ref_mem[ma] = wd[8*k +: 8];
                wq.push_back('{cyc + 1 + k, ma, wd[8*k +: 8]});
            end
            dq.push_back('{cyc + n + 1, cur_rdata, 1'b0});
            bfrom = cyc + 1; bto = cyc + n;
            last_done = cyc + n + 1;
        end else begin
            v = '0;
            for (int k = 0; k < n; k++) begin
                ma = a[9:0] + 10'(k);
                v[8*k +: 8] = ref_mem[ma];
                rq.push_back('{cyc + 1 + k, ma});
            end
            if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
            cur_rdata = v;
            dq.push_back('{cyc + n + 2, v, 1'b0});
            bfrom = cyc + 1; bto = cyc + n + 1;
            last_done = cyc + n + 2;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        while (cyc < last_done) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [3:0] code_of(input int i);
        case (i)
            0: return 4'b1000; 1: return 4'b1001; 2: return 4'b1010; 3: return 4'b1100;
            4: return 4'b1101; 5: return 4'b1011; 6: return 4'b1110; default: return 4'b1111;
        endcase
    endfunction

    initial begin
        logic [31:0] ra;
        for (int i = 0; i < 1024; i++) begin sram[i] = 8'h00; ref_mem[i] = 8'h00; end
        bus.start = 1'b0; bus.read_write = 4'h0; bus.addr = '0; bus.wdata = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_re", bus.mem_re, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_mwdata", bus.mem_wdata, 0);
        idle(2);
        rst = 1'b1;
        idle(2);

        issue(4'b1111, 32'h010, 32'hDEADBEEF); wait_done(); idle(1);
        issue(4'b1000, 32'h011, 32'h0); wait_done();
        chk("lb_const", bus.rdata, 32'hFFFFFFBE);
        issue(4'b1100, 32'h011, 32'h0); wait_done();
        chk("lbu_const", bus.rdata, 32'h000000BE);
        issue(4'b1001, 32'h012, 32'h0); wait_done();
        chk("lh_const", bus.rdata, 32'hFFFFDEAD);
        issue(4'b1101, 32'h012, 32'h0); wait_done();
        chk("lhu_const", bus.rdata, 32'h0000DEAD);
        issue(4'b1010, 32'h010, 32'h0); wait_done();
        chk("lw_const", bus.rdata, 32'hDEADBEEF);
        issue(4'b1110, 32'h013, 32'h1234); wait_done();
        issue(4'b1010, 32'h012, 32'h0); wait_done();
        chk("mis_rdata_kept", bus.rdata, 32'hDEADBEEF);
        idle(2);

        // starts during a load and a no-access start while idle must be ignored
        issue(4'b1010, 32'h010, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            bus.start = 1'b1; bus.read_write = 4'b1011; bus.addr = 32'h3FF; bus.wdata = 32'hA5A5A5A5;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        wait_done(); idle(1);
        bus.start = 1'b1; bus.read_write = 4'b0000; bus.addr = 32'h020;
        @(posedge clk); #1;
        bus.start = 1'b0;
        idle(3);

        // asynchronous reset in cycle 3 of a word load
        issue(4'b1010, 32'h010, 32'h0);
        idle(2);
        rst = 1'b0;
        dq.delete(); rq.delete();
        bto = 0; cur_rdata = '0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_rdata", bus.rdata, 0);
        chk("abort_re", bus.mem_re, 0);
        chk("abort_maddr", bus.mem_addr, 0);
        idle(1);
        rst = 1'b1;
        last_done = cyc;
        issue(4'b1011, 32'h000, 32'h0000005A); wait_done();
        issue(4'b1100, 32'h000, 32'h0); wait_done();
        chk("sb_readback", bus.rdata, 32'h0000005A);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            ra[9:6] = 4'h4;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            issue(code_of($urandom_range(0, 7)), ra, $urandom());
            wait_done();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        idle(4);
        chk("dq_drained", dq.size(), 0);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
